// File: rtl/eq_gain_writer.sv
// Byte-serial register-write initiator for the equalizer register map.
// Optional broadcast of one gain to every band: define EQ_GAIN_WRITER_BROADCAST_EN.
module eq_gain_writer #(
   parameter int GAIN_WIDTH = 24,
   parameter int ADDR_WIDTH = 31,
   parameter int NUM_BANDS  = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [3:0]            cmd_sel,
   input  logic [GAIN_WIDTH-1:0] cmd_data,
   output logic                  we,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic [7:0]            wr_data,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int NBYTES = GAIN_WIDTH / 8;
   localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [BW-1:0] LAST_BYTE = BW'(NBYTES - 1);

   typedef enum logic [1:0] {IDLE, WRITE, FINISH} state_t;

   state_t                  state_q;
   logic                    ready_q, we_q, busy_q, done_q, err_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [7:0]              wr_data_q;
   logic [BW-1:0]           byte_q;
   logic [GAIN_WIDTH-1:0]   gain_q;
`ifdef EQ_GAIN_WRITER_BROADCAST_EN
   localparam int BCW = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
   logic [BCW-1:0]          bands_left_q;
`endif

   logic                    accept, sel_cfg, sel_band, sel_bcast;
   logic [ADDR_WIDTH-1:0]   start_addr;
   logic [BW-1:0]           byte_nxt;

   function automatic logic [7:0] pick_byte(input logic [GAIN_WIDTH-1:0] w,
                                            input logic [BW-1:0] k);
      return 8'(w >> {k, 3'b000});
   endfunction

   always_comb begin
      accept     = cmd_valid && ready_q;
      sel_cfg    = (cmd_sel == 4'd0);
      sel_band   = (cmd_sel != 4'd0) && (int'(cmd_sel) <= NUM_BANDS);
`ifdef EQ_GAIN_WRITER_BROADCAST_EN
      sel_bcast  = (cmd_sel == 4'hF);
`else
      sel_bcast  = 1'b0;
`endif
      start_addr = ADDR_WIDTH'(NBYTES) * (ADDR_WIDTH'(cmd_sel) - ADDR_WIDTH'(1)) + ADDR_WIDTH'(1);
      byte_nxt   = byte_q + BW'(1);
   end

   // Gain word is pure data: captured on accept, never reset.
   always_ff @(posedge clk) begin
      if (accept) gain_q <= cmd_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         ready_q   <= 1'b0;
         we_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         addr_q    <= '0;
         wr_data_q <= '0;
         byte_q    <= '0;
`ifdef EQ_GAIN_WRITER_BROADCAST_EN
         bands_left_q <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            IDLE, FINISH: begin
               we_q    <= 1'b0;
               busy_q  <= 1'b0;
               ready_q <= 1'b1;
               state_q <= IDLE;
               if (accept) begin
                  if (sel_cfg || sel_band || sel_bcast) begin
                     state_q   <= WRITE;
                     ready_q   <= 1'b0;
                     we_q      <= 1'b1;
                     busy_q    <= 1'b1;
                     wr_data_q <= cmd_data[7:0];
                     addr_q    <= sel_cfg ? '0 : (sel_bcast ? ADDR_WIDTH'(1) : start_addr);
                     // Configuration is a one-byte write: start on the last byte.
                     byte_q    <= sel_cfg ? LAST_BYTE : '0;
`ifdef EQ_GAIN_WRITER_BROADCAST_EN
                     bands_left_q <= sel_bcast ? BCW'(NUM_BANDS - 1) : '0;
`endif
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            WRITE: begin
               if (byte_q == LAST_BYTE) begin
`ifdef EQ_GAIN_WRITER_BROADCAST_EN
                  if (bands_left_q != '0) begin
                     bands_left_q <= bands_left_q - BCW'(1);
                     byte_q       <= '0;
                     addr_q       <= addr_q + ADDR_WIDTH'(1);
                     wr_data_q    <= gain_q[7:0];
                  end else begin
                     state_q <= FINISH;
                     we_q    <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     ready_q <= 1'b1;
                  end
`else
                  state_q <= FINISH;
                  we_q    <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  ready_q <= 1'b1;
`endif
               end else begin
                  byte_q    <= byte_nxt;
                  addr_q    <= addr_q + ADDR_WIDTH'(1);
                  wr_data_q <= pick_byte(gain_q, byte_nxt);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cmd_ready = ready_q;
   assign we        = we_q;
   assign addr      = addr_q;
   assign wr_data   = wr_data_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule
